// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and helpers for the bit-serial subtractor.
//   Contents:
//     state_t       control FSM encoding (IDLE -> RUN -> DONE -> IDLE)
//     sub_ovf()     signed-overflow rule for a - b, from the three MSBs
// -----------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for operands, in_ready high
      RUN  = 2'd1,   // one result bit per clock, LSB first
      DONE = 2'd2    // result held until the consumer takes it
   } state_t;

   // Two's-complement a - b overflows only when the operands have different
   // signs and the result sign differs from the minuend sign.
   function automatic logic sub_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic d_msb);
      return (a_msb ^ b_msb) & (a_msb ^ d_msb);
   endfunction

endpackage : serial_sub_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor / full_subtractor
//   One-bit subtract cells for the serial datapath.
//   half_subtractor : d = a ^ b, bout = ~a & b
//   full_subtractor : d = a ^ b ^ bin
//                     bout = (~a & b) | (~(a ^ b) & bin)
//   The full cell is two half stages (a - b, then that result - bin) whose
//   borrows are ORed; both borrows can never be high together.
//   Ports (full_subtractor):
//     a, b   in  1   operand bits
//     bin    in  1   borrow in from the previous (less significant) bit
//     d      out 1   difference bit
//     bout   out 1   borrow out to the next bit
// -----------------------------------------------------------------------------
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);
   assign d    = a ^ b;
   assign bout = ~a & b;
endmodule : half_subtractor

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic w_d1;
   logic w_bout1;
   logic w_bout2;

   // first stage: a - b
   half_subtractor u_hs_ab (
      .a    (a),
      .b    (b),
      .d    (w_d1),
      .bout (w_bout1)
   );

   // second stage: (a - b) - bin; its borrow is ~(a^b) & bin
   half_subtractor u_hs_bin (
      .a    (w_d1),
      .b    (bin),
      .d    (d),
      .bout (w_bout2)
   );

   assign bout = w_bout1 | w_bout2;
endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b, computed LSB first, one bit
//   per clock through a single full_subtractor cell. Operands enter through a
//   valid/ready handshake, the result leaves through another.
//
//   Parameters:
//     WIDTH      operand/result width in bits (>= 1)
//
//   Build option:
//     SERIAL_SUB_OVF_EN  when defined, adds the ovf port (signed overflow) and
//                        the two flops that capture the operand sign bits.
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      operands a/b valid
//     in_ready   out  1      operands accepted (high only in IDLE)
//     a          in   WIDTH  minuend
//     b          in   WIDTH  subtrahend
//     out_valid  out  1      diff/borrow(/ovf) valid
//     out_ready  in   1      consumer takes the result
//     diff       out  WIDTH  a - b modulo 2^WIDTH
//     borrow     out  1      1 when a < b (unsigned)
//     ovf        out  1      signed overflow (SERIAL_SUB_OVF_EN only)
//     busy       out  1      high in RUN or DONE
//
//   Timing: operands are accepted on edge E0. Edges E1..E(WIDTH) each retire
//   one bit; edge E(WIDTH+1) sees the full count and moves to DONE, so
//   out_valid rises WIDTH+1 clocks after the accepting edge.
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t           r_state;
   logic [WIDTH-1:0] r_a;          // minuend, shifted right each bit-cycle
   logic [WIDTH-1:0] r_b;          // subtrahend, shifted right each bit-cycle
   logic [WIDTH-1:0] r_diff;       // result, filled from the MSB end
   logic             r_borrow;     // running borrow; final bout once in DONE
   logic [CNT_W-1:0] r_cnt;        // bits retired so far
   logic             r_in_ready;
   logic             r_out_valid;
   logic             r_busy;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_a_msb;      // operand signs captured at load
   logic             r_b_msb;
   logic             r_ovf;
`endif

   // ---------------------------------------------------------------------------
   // Bit-serial datapath: one full subtractor on the current LSBs
   // ---------------------------------------------------------------------------
   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_diff_next;

   full_subtractor u_full_sub (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_bout)
   );

   // New bit enters at the MSB; after WIDTH shifts the first (LSB) result bit
   // has travelled down to bit 0. A one-bit result has nothing to shift.
   generate
      if (WIDTH == 1) begin : g_diff_w1
         assign w_diff_next = w_d;
      end else begin : g_diff_wn
         assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Control FSM with registered outputs
   // ---------------------------------------------------------------------------
   // NOTE: every register here uses <= so all updates see the pre-edge values;
   // a blocking = would let later statements read the freshly written value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_a_msb     <= 1'b0;
         r_b_msb     <= 1'b0;
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_cnt      <= '0;
                  r_borrow   <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  r_a_msb    <= a[WIDTH-1];
                  r_b_msb    <= b[WIDTH-1];
`endif
                  r_state    <= RUN;
               end
            end

            RUN: begin
               if (r_cnt == CNT_LAST) begin
                  // all bits retired: r_diff and r_borrow are final
                  r_out_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf       <= sub_ovf(r_a_msb, r_b_msb, r_diff[WIDTH-1]);
`endif
                  r_state     <= DONE;
               end else begin
                  r_a      <= r_a >> 1;
                  r_b      <= r_b >> 1;
                  r_diff   <= w_diff_next;
                  r_borrow <= w_bout;
                  r_cnt    <= r_cnt + 1'b1;
               end
            end

            DONE: begin
               // result registers are left untouched, so they stay stable
               // for as long as the consumer holds off
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf       <= 1'b0;
`endif
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign borrow    = r_borrow;
   assign busy      = r_busy;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule : serial_subtractor
